// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and request type for the register-file write-back path.
package regfile_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_CSR = 2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at the pointer,
// pointer moves to one past the winner.
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  localparam logic [PTR_W:0]   NUM  = (PTR_W+1)'(N);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   cand;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= NUM) cand = cand - NUM;
      if (!grant_valid && req[cand[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port plus pending-write
// scoreboard. Define WB_BYPASS_EN to add the commit-cycle forwarding outputs.
import regfile_pkg::*;

module regfile_wb_arbiter #(
  parameter int NUM_REQ = regfile_pkg::NUM_REQ,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_rd,
  input  logic [ADDR_W-1:0]         Rs1,
  input  logic [ADDR_W-1:0]         Rs2,
  output logic                      rs1_pending,
  output logic                      rs2_pending,
`ifdef WB_BYPASS_EN
  output logic                      rs1_fwd_valid,
  output logic                      rs2_fwd_valid,
  output logic [DATA_W-1:0]         fwd_data,
`endif
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         Rd,
  output logic [DATA_W-1:0]         Write_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              commit;
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .grant       (req_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_rd   = req_rd[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

  // A grant to x0 completes the handshake but never reaches the register file.
  assign commit = grant_valid && (sel_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      Rd         <= '0;
      Write_data <= '0;
    end else begin
      RegWrite <= commit;
      if (commit) begin
        Rd         <= sel_rd;
        Write_data <= sel_data;
      end
    end
  end

  // Set after clear, so a fresh allocation survives a same-cycle commit.
  always_comb begin
    pending_next = pending;
    if (RegWrite) pending_next[Rd] = 1'b0;
    if (alloc_valid) pending_next[alloc_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

`ifdef WB_BYPASS_EN
  assign rs1_fwd_valid = RegWrite && (Rd == Rs1) && (Rd != '0);
  assign rs2_fwd_valid = RegWrite && (Rd == Rs2) && (Rd != '0);
  assign fwd_data      = Write_data;
  assign rs1_pending   = pending[Rs1] && !rs1_fwd_valid;
  assign rs2_pending   = pending[Rs2] && !rs2_fwd_valid;
`else
  assign rs1_pending   = pending[Rs1];
  assign rs2_pending   = pending[Rs2];
`endif

endmodule
